// File: rtl/div_uint8_seq.sv
// Iterative restoring divider: one quotient bit per clock, ready/valid on both sides.
// Optional two's-complement operation when DIV_SIGNED_EN is defined (default: unsigned only).
module div_uint8_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] R,
  output logic             div_by_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // BUSY  | one restoring step per edge, cnt counts down to 0
  // DONE  | result held on O/R/div_by_zero until out_ready
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  logic [WIDTH-1:0] ld_a;
  logic [WIDTH-1:0] ld_b;
  logic [WIDTH-1:0] fin_o;
  logic [WIDTH-1:0] fin_r;
  logic             fin_z;

`ifdef DIV_SIGNED_EN
  logic sgn_a;
  logic sgn_b;
`endif

  // dvd doubles as the quotient register: dividend bits shift out the top
  // while quotient bits shift in at the bottom.
  always_comb begin
    rem_sh   = {rem, dvd[WIDTH-1]};
    trial    = rem_sh - {1'b0, dvs};
    trial_ok = ~trial[WIDTH];
    rem_nxt  = trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_nxt  = {dvd[WIDTH-2:0], trial_ok};
    fin_z    = (dvs == '0);
`ifdef DIV_SIGNED_EN
    ld_a  = I0[WIDTH-1] ? -I0 : I0;
    ld_b  = I1[WIDTH-1] ? -I1 : I1;
    // Divide-by-zero keeps the raw all-ones quotient regardless of signs.
    if (fin_z)
      fin_o = '1;
    else
      fin_o = (sgn_a ^ sgn_b) ? -dvd_nxt : dvd_nxt;
    fin_r = sgn_a ? -rem_nxt : rem_nxt;
`else
    ld_a  = I0;
    ld_b  = I1;
    fin_o = dvd_nxt;
    fin_r = rem_nxt;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      O           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_a       <= 1'b0;
      sgn_b       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd      <= ld_a;
            dvs      <= ld_b;
            rem      <= '0;
            cnt      <= CW'(WIDTH - 1);
            in_ready <= 1'b0;
            state    <= BUSY;
`ifdef DIV_SIGNED_EN
            sgn_a    <= I0[WIDTH-1];
            sgn_b    <= I1[WIDTH-1];
`endif
          end
        end
        BUSY: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            O           <= fin_o;
            R           <= fin_r;
            div_by_zero <= fin_z;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
